// File: rtl/fp_normalizer.sv
// Two-stage pipelined left-normalizer for the FPU add/sub datapath (leading-zero count, shift, exponent adjust).
// Define FP_NORM_DENORM_EN for gradual underflow; leave it undefined to flush underflows to zero.
module fp_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [23:0] mant_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic [7:0]  exp_out,
  output logic [22:0] mant_out,
  output logic        zero_out,
  output logic        uflow_out
);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic [4:0]  lz;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
    logic        zero;
    logic        uflow;
  } res_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  res_t s2_q, s2_d;
  res_t res;
  logic s1_ready, s2_ready;
  logic [7:0] lz_ext;

  // Last hit wins, so the result reflects the most significant set bit.
  function automatic logic [4:0] count_lz(input logic [23:0] m);
    count_lz = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) count_lz = 5'(23 - i);
    end
  endfunction

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;
  assign lz_ext   = {3'b000, s1_q.lz};

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_d = '{sign: sign_in, exp: exp_in, mant: mant_in, lz: count_lz(mant_in)};
    end
  end

  always_comb begin
    res      = '0;
    res.sign = s1_q.sign;
    if (s1_q.mant == 24'd0) begin
      res.zero = 1'b1;
    end else if (s1_q.exp > lz_ext) begin
      res.exp  = s1_q.exp - lz_ext;
      res.mant = 23'(s1_q.mant << s1_q.lz);
    end else begin
`ifdef FP_NORM_DENORM_EN
      // Shift only as far as the denormal range allows; exp stays encoded as 0.
      res.mant  = (s1_q.exp == 8'd0) ? s1_q.mant[22:0] : 23'(s1_q.mant << (s1_q.exp - 8'd1));
      res.uflow = 1'b1;
`else
      res.uflow = 1'b1;
`endif
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = res;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign sign_out  = s2_q.sign;
  assign exp_out   = s2_q.exp;
  assign mant_out  = s2_q.mant;
  assign zero_out  = s2_q.zero;
  assign uflow_out = s2_q.uflow;

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: driver pushes expected results, a monitor pops them on output transfers.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [23:0] mant_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] mant_out;
  logic        zero_out;
  logic        uflow_out;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
    logic        zero;
    logic        uflow;
    bit          chk_lat;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   accepted = 0;

  fp_normalizer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out),
    .zero_out(zero_out), .uflow_out(uflow_out)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Call just after a rising edge; returns just after the edge that accepted the operand.
  task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                      input logic xs, input logic [7:0] xe, input logic [22:0] xm,
                      input logic xz, input logic xu, input bit lat);
    bit   acc;
    int   waited = 0;
    exp_t it;
    in_valid = 1'b1; sign_in = s; exp_in = e; mant_in = m;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        it = '{sign: xs, exp: xe, mant: xm, zero: xz, uflow: xu, chk_lat: lat, cyc: cyc};
        q.push_back(it);
        accepted++;
      end
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 200);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, q.size(), 0);
  endtask

  // Monitor: compares on output transfers and checks stability while stalled.
  initial begin
    exp_t it;
    bit   hold_armed = 0;
    logic [33:0] held;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_armed = 0;
      end else begin
        if (hold_armed) begin
          check("hold_valid", out_valid, 1);
          check("hold_fields", {sign_out, exp_out, mant_out, zero_out, uflow_out}, held);
        end
        hold_armed = 0;
        if (out_valid && !out_ready) begin
          hold_armed = 1;
          held = {sign_out, exp_out, mant_out, zero_out, uflow_out};
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
          end else begin
            it = q.pop_front();
            check("sign_out", sign_out, it.sign);
            check("exp_out", exp_out, it.exp);
            check("mant_out", mant_out, it.mant);
            check("zero_out", zero_out, it.zero);
            check("uflow_out", uflow_out, it.uflow);
            if (it.chk_lat) check("latency", cyc - it.cyc, 2);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; mant_in = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_fields", {sign_out, exp_out, mant_out, zero_out, uflow_out}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("in_ready_after_rst", in_ready, 1);

    // Directed vectors, out_ready high, back-to-back.
    send(0, 8'd127, 24'h800000, 0, 8'd127, 23'h000000, 0, 0, 1);
    send(0, 8'd100, 24'h000300, 0, 8'd86,  23'h400000, 0, 0, 1);
    send(1, 8'd50,  24'h000000, 1, 8'd0,   23'h000000, 1, 0, 1);
`ifdef FP_NORM_DENORM_EN
    send(0, 8'd10,  24'h000100, 0, 8'd0,   23'h020000, 0, 1, 1);
    send(0, 8'd1,   24'h400000, 0, 8'd0,   23'h400000, 0, 1, 1);
    send(1, 8'd0,   24'hFFFFFF, 1, 8'd0,   23'h7FFFFF, 0, 1, 1);
`else
    send(0, 8'd10,  24'h000100, 0, 8'd0,   23'h000000, 0, 1, 1);
    send(0, 8'd1,   24'h400000, 0, 8'd0,   23'h000000, 0, 1, 1);
    send(1, 8'd0,   24'hFFFFFF, 1, 8'd0,   23'h000000, 0, 1, 1);
`endif
    send(0, 8'd2,   24'h400000, 0, 8'd1,   23'h000000, 0, 0, 1);
    send(0, 8'd200, 24'h000001, 0, 8'd177, 23'h000000, 0, 0, 1);
    send(1, 8'd255, 24'hC00000, 1, 8'd255, 23'h400000, 0, 0, 1);
    send(0, 8'd30,  24'h0ABCDE, 0, 8'd26,  23'h2BCDE0, 0, 0, 1);
    drain("drain_directed");

    // Backpressure: 4 operands with out_ready low for 5 cycles.
    out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        send(0, 8'd90, 24'h123456, 0, 8'd87, 23'h11A2B0, 0, 0, 0);
        send(1, 8'd64, 24'h00F000, 1, 8'd56, 23'h700000, 0, 0, 0);
        send(0, 8'd5,  24'h800001, 0, 8'd5,  23'h000001, 0, 0, 0);
        send(0, 8'd23, 24'h000002, 0, 8'd1,  23'h000000, 0, 0, 0);
      end
    join_none
    repeat (5) @(posedge clk);
    #1;
    check("bp_accepted", accepted, 2);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    #1 check("bp_in_ready_rise", in_ready, 1);
    wait fork;
    drain("drain_backpressure");
    check("bp_all_accepted", accepted, 4);

    // Reset with both stages full: in-flight results discarded.
    out_ready = 1'b0;
    send(0, 8'd40, 24'h010000, 0, 8'd33, 23'h000000, 0, 0, 0);
    send(0, 8'd41, 24'h020000, 0, 8'd35, 23'h000000, 0, 0, 0);
    @(posedge clk); #1;
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    q.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_fields", {sign_out, exp_out, mant_out, zero_out, uflow_out}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1);
    send(0, 8'd100, 24'h000300, 0, 8'd86, 23'h400000, 0, 0, 1);
    drain("drain_after_reset");
    repeat (3) @(posedge clk);
    #1 check("idle_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
